// File: rtl/fg_bd_fifo_ext.sv
// Descriptor FIFO: DEPTH-entry RAM feeding one output register, with occupancy,
// byte accounting, threshold flags and optional discard of zero-length descriptors.
module fg_bd_fifo_ext #(
    parameter int ADDR_WIDTH          = 10,
    parameter int DEST_WIDTH          = 8,
    parameter int LEN_WIDTH           = 32,
    parameter int ALMOST_FULL_THRESH  = (2 ** ADDR_WIDTH) - 4,
    parameter int ALMOST_EMPTY_THRESH = 4,
    parameter int DROP_ZERO_LEN       = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           input_bd_valid,
    output logic                           input_bd_ready,
    input  logic [DEST_WIDTH-1:0]          input_bd_dest,
    input  logic [LEN_WIDTH-1:0]           input_bd_burst_len,
    output logic                           output_bd_valid,
    input  logic                           output_bd_ready,
    output logic [DEST_WIDTH-1:0]          output_bd_dest,
    output logic [LEN_WIDTH-1:0]           output_bd_burst_len,
    output logic [ADDR_WIDTH:0]            count,
    output logic [ADDR_WIDTH+LEN_WIDTH-1:0] byte_count,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic                           drop
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int BW    = ADDR_WIDTH + LEN_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_THRESH);

    typedef struct packed {
        logic [DEST_WIDTH-1:0] dest;
        logic [LEN_WIDTH-1:0]  len;
    } bd_t;

    bd_t mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [BW-1:0]         byte_count_q, byte_count_d;
    logic                  out_valid_q, out_valid_d;
    bd_t                   out_q, out_d;
    logic                  drop_q, drop_d;

    logic          accept, store, out_xfer, load;
    logic [CW-1:0] ram_cnt;

    assign full           = (count_q == DEPTH_C);
    assign empty          = (count_q == '0);
    assign almost_full    = (count_q >= AF_C);
    assign almost_empty   = (count_q <= AE_C);
    assign input_bd_ready = rst_n && !full && !flush;

    assign count               = count_q;
    assign byte_count          = byte_count_q;
    assign output_bd_valid     = out_valid_q;
    assign output_bd_dest      = out_q.dest;
    assign output_bd_burst_len = out_q.len;
    assign drop                = drop_q;

    assign accept   = input_bd_valid && input_bd_ready;
    assign store    = accept && !((input_bd_burst_len == '0) && (DROP_ZERO_LEN != 0));
    assign out_xfer = out_valid_q && output_bd_ready && !flush;
    // Entries still in RAM: the output register's entry is part of count.
    assign ram_cnt  = count_q - CW'(out_valid_q);
    assign load     = (ram_cnt != '0) && (!out_valid_q || out_xfer);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        count_d      = count_q + CW'(store) - CW'(out_xfer);
        byte_count_d = byte_count_q
                     + (store ? BW'(input_bd_burst_len) : '0)
                     - (out_xfer ? BW'(out_q.len) : '0);
        drop_d       = accept && !store;
        if (store) wr_ptr_d = wr_ptr_q + 1'b1;
        if (load) begin
            rd_ptr_d    = rd_ptr_q + 1'b1;
            out_d       = mem[rd_ptr_q];
            out_valid_d = 1'b1;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            out_valid_d  = 1'b0;
            count_d      = '0;
            byte_count_d = '0;
            drop_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            byte_count_q <= '0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            drop_q       <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            byte_count_q <= byte_count_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            drop_q       <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr_q] <= '{dest: input_bd_dest, len: input_bd_burst_len};
    end
endmodule

// File: tb/tb_fg_bd_fifo_ext.sv
// Randomized and directed bench for fg_bd_fifo_ext (DEPTH=16) against a queue model.
module tb_fg_bd_fifo_ext;
    logic        clk = 0;
    logic        rst_n = 0, flush = 0;
    logic        in_v = 0, out_r = 0;
    logic [7:0]  in_d = 0;
    logic [31:0] in_l = 0;

    logic        input_bd_ready, output_bd_valid, full, empty, almost_full, almost_empty, drop;
    logic [7:0]  output_bd_dest;
    logic [31:0] output_bd_burst_len;
    logic [4:0]  count;
    logic [35:0] byte_count;

    logic        d2_ready, d2_valid, d2_full, d2_empty, d2_af, d2_ae, d2_drop;
    logic [7:0]  d2_dest;
    logic [31:0] d2_len;
    logic [4:0]  d2_count;
    logic [35:0] d2_bytes;

    int n_checks = 0, n_fail = 0;
    int order_err = 0, hold_err = 0;
    logic [39:0] q[$];
    logic pre_rdy, pre_ov;

    always #5 clk = ~clk;

    fg_bd_fifo_ext #(.ADDR_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .input_bd_valid(in_v), .input_bd_ready(input_bd_ready),
        .input_bd_dest(in_d), .input_bd_burst_len(in_l),
        .output_bd_valid(output_bd_valid), .output_bd_ready(out_r),
        .output_bd_dest(output_bd_dest), .output_bd_burst_len(output_bd_burst_len),
        .count(count), .byte_count(byte_count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .drop(drop));

    fg_bd_fifo_ext #(.ADDR_WIDTH(4), .DROP_ZERO_LEN(0)) dut_keep (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .input_bd_valid(in_v), .input_bd_ready(d2_ready),
        .input_bd_dest(in_d), .input_bd_burst_len(in_l),
        .output_bd_valid(d2_valid), .output_bd_ready(out_r),
        .output_bd_dest(d2_dest), .output_bd_burst_len(d2_len),
        .count(d2_count), .byte_count(d2_bytes), .full(d2_full), .empty(d2_empty),
        .almost_full(d2_af), .almost_empty(d2_ae), .drop(d2_drop));

    function automatic logic [35:0] qsum();
        logic [35:0] s = 0;
        foreach (q[i]) s += 36'(q[i][31:0]);
        return s;
    endfunction

    // One clock: drive at negedge, update the model from pre-edge state, return at next negedge.
    logic exp_drop = 0;
    task automatic step(input logic v, input logic [7:0] d, input logic [31:0] l,
                        input logic r, input logic f);
        logic hold;
        logic [39:0] held;
        in_v = v; in_d = d; in_l = l; out_r = r; flush = f;
        #1;
        pre_rdy = input_bd_ready;
        pre_ov  = output_bd_valid;
        hold    = output_bd_valid && !r && !f;
        held    = {output_bd_dest, output_bd_burst_len};
        if (output_bd_valid && r && !f) begin
            if (q.size() == 0 || {output_bd_dest, output_bd_burst_len} !== q[0]) order_err++;
            if (q.size() != 0) void'(q.pop_front());
        end
        exp_drop = 0;
        if (v && pre_rdy) begin
            if (l == 0) exp_drop = 1;
            else q.push_back({d, l});
        end
        if (f) q.delete();
        @(posedge clk);
        @(negedge clk);
        if (hold && (!output_bd_valid || {output_bd_dest, output_bd_burst_len} !== held)) hold_err++;
    endtask

    task automatic apply_reset();
        rst_n = 0; in_v = 0; out_r = 0; flush = 0;
        @(posedge clk); @(negedge clk);
        rst_n = 1;
        q.delete();
        exp_drop = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; in_v = 1; in_l = 5;
        #1;
        n_checks++;
        if (input_bd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", input_bd_ready); end
        apply_reset();
        n_checks++;
        if ({count, byte_count, output_bd_valid, drop, full, empty, almost_full, almost_empty}
            !== {5'd0, 36'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state got cnt=%0d bytes=%0d v=%b drop=%b f=%b e=%b af=%b ae=%b want 0 0 0 0 0 1 0 1",
                     count, byte_count, output_bd_valid, drop, full, empty, almost_full, almost_empty);
        end
    endtask

    task automatic test_single();
        step(1, 8'h12, 100, 1, 0);
        n_checks++;
        if (count !== 5'd1 || byte_count !== 36'd100) begin
            n_fail++; $display("FAIL single_store got cnt=%0d bytes=%0d want 1 100", count, byte_count);
        end
        step(0, 0, 0, 1, 0);
        n_checks++;
        if (output_bd_valid !== 1'b1 || output_bd_dest !== 8'h12 || output_bd_burst_len !== 32'd100) begin
            n_fail++; $display("FAIL single_latency got v=%b d=%h l=%0d want 1 12 100",
                               output_bd_valid, output_bd_dest, output_bd_burst_len);
        end
        step(0, 0, 0, 1, 0);
        n_checks++;
        if (count !== 5'd0 || byte_count !== 36'd0 || output_bd_valid !== 1'b0 || order_err != 0) begin
            n_fail++; $display("FAIL single_drain got cnt=%0d bytes=%0d v=%b oerr=%0d want 0 0 0 0",
                               count, byte_count, output_bd_valid, order_err);
        end
    endtask

    task automatic test_drop();
        apply_reset();
        step(1, 8'h5A, 0, 1, 0);
        n_checks++;
        if (drop !== 1'b1 || count !== 5'd0 || d2_count !== 5'd1 || d2_drop !== 1'b0) begin
            n_fail++; $display("FAIL drop_pulse got drop=%b cnt=%0d keep_cnt=%0d keep_drop=%b want 1 0 1 0",
                               drop, count, d2_count, d2_drop);
        end
        step(0, 0, 0, 1, 0);
        n_checks++;
        if (drop !== 1'b0 || output_bd_valid !== 1'b0 || d2_valid !== 1'b1 ||
            d2_dest !== 8'h5A || d2_len !== 32'd0) begin
            n_fail++; $display("FAIL drop_after got drop=%b v=%b keep_v=%b keep_d=%h keep_l=%0d want 0 0 1 5a 0",
                               drop, output_bd_valid, d2_valid, d2_dest, d2_len);
        end
        step(0, 0, 0, 1, 0);
        n_checks++;
        if (d2_count !== 5'd0 || count !== 5'd0) begin
            n_fail++; $display("FAIL drop_keep_drain got keep_cnt=%0d cnt=%0d want 0 0", d2_count, count);
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 17; i++) step(1, 8'(i), 1, 0, 0);
        n_checks++;
        if (count !== 5'd16 || byte_count !== 36'd16 || full !== 1'b1 || input_bd_ready !== 1'b0 ||
            q.size() != 16) begin
            n_fail++; $display("FAIL full_state got cnt=%0d bytes=%0d full=%b rdy=%b model=%0d want 16 16 1 0 16",
                               count, byte_count, full, input_bd_ready, q.size());
        end
        n_checks++;
        if (hold_err != 0) begin n_fail++; $display("FAIL full_hold got errs=%0d want 0", hold_err); end
        for (int i = 0; i < 40 && q.size() != 0; i++) step(0, 0, 0, 1, 0);
        n_checks++;
        if (q.size() != 0 || count !== 5'd0 || empty !== 1'b1 || order_err != 0) begin
            n_fail++; $display("FAIL full_drain got left=%0d cnt=%0d empty=%b oerr=%0d want 0 0 1 0",
                               q.size(), count, empty, order_err);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) step(1, 8'(8'h80 + i), 10, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 48; i++) begin
            step(1, 8'(i), 10, 1, 0);
            if (!pre_ov || count !== 5'd5 || byte_count !== 36'd50) bad++;
        end
        n_checks++;
        if (bad != 0 || order_err != 0) begin
            n_fail++; $display("FAIL stream got bad_cycles=%0d oerr=%0d want 0 0", bad, order_err);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 5; i++) step(1, 8'(i), 8, 0, 0);
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (count !== 5'd5 || byte_count !== 36'd40) begin
            n_fail++; $display("FAIL flush_load got cnt=%0d bytes=%0d want 5 40", count, byte_count);
        end
        step(1, 8'hEE, 8, 1, 1);
        n_checks++;
        if (count !== 5'd0 || byte_count !== 36'd0 || output_bd_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear got cnt=%0d bytes=%0d v=%b want 0 0 0",
                               count, byte_count, output_bd_valid);
        end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        n_checks++;
        if (output_bd_valid !== 1'b0 || count !== 5'd0) begin
            n_fail++; $display("FAIL flush_absent got v=%b cnt=%0d want 0 0", output_bd_valid, count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 7, 0, 0);
        apply_reset();
        n_checks++;
        if ({count, byte_count, output_bd_valid, drop, full, empty, almost_full, almost_empty}
            !== {5'd0, 36'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL midreset_state got cnt=%0d bytes=%0d v=%b e=%b", count, byte_count,
                               output_bd_valid, empty);
        end
        step(1, 8'h77, 33, 0, 0);
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (output_bd_valid !== 1'b1 || output_bd_dest !== 8'h77 || output_bd_burst_len !== 32'd33) begin
            n_fail++; $display("FAIL midreset_first got v=%b d=%h l=%0d want 1 77 33",
                               output_bd_valid, output_bd_dest, output_bd_burst_len);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        int n;
        logic f, exp_rdy;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            f = ($urandom_range(0, 24) == 0);
            exp_rdy = (q.size() != 16) && !f;
            step($urandom_range(0, 3) != 0, 8'($urandom), 32'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0, f);
            n = q.size();
            if (pre_rdy !== exp_rdy) bad++;
            if (count !== 5'(n) || byte_count !== qsum()) bad++;
            if (empty !== (n == 0) || full !== (n == 16)) bad++;
            if (almost_full !== (n >= 12) || almost_empty !== (n <= 4)) bad++;
            if (drop !== exp_drop) bad++;
            if (n == 0 && output_bd_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL random_status got errs=%0d want 0", bad); end
        n_checks++;
        if (order_err != 0 || hold_err != 0) begin
            n_fail++; $display("FAIL random_order got oerr=%0d herr=%0d want 0 0", order_err, hold_err);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_drop();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fg_bd_fifo_ext.md
FG_BD_FIFO_EXT -- requirements
Module: fg_bd_fifo_ext

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 10, log2 of storage depth; DEPTH = 2^ADDR_WIDTH entries.
REQ-002 SHALL provide parameter DEST_WIDTH, default 8, width of descriptor dest field.
REQ-003 SHALL provide parameter LEN_WIDTH, default 32, width of descriptor burst_len field.
REQ-004 SHALL provide parameter ALMOST_FULL_THRESH, default DEPTH-4, count level asserting almost_full.
REQ-005 SHALL provide parameter ALMOST_EMPTY_THRESH, default 4, count level asserting almost_empty.
REQ-006 SHALL provide parameter DROP_ZERO_LEN, default 1, when 1 discard descriptors with burst_len 0.
REQ-007 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 flush  in  1  synchronous clear of all stored descriptors.
REQ-010 input_bd_valid  in  1 / input_bd_ready  out  1  input handshake.
REQ-011 input_bd_dest  in  DEST_WIDTH / input_bd_burst_len  in  LEN_WIDTH  input descriptor.
REQ-012 output_bd_valid  out  1 / output_bd_ready  in  1  output handshake.
REQ-013 output_bd_dest  out  DEST_WIDTH / output_bd_burst_len  out  LEN_WIDTH  output descriptor.
REQ-014 count  out  ADDR_WIDTH+1  descriptors held (0..DEPTH).
REQ-015 byte_count  out  ADDR_WIDTH+LEN_WIDTH  sum of burst_len of held descriptors.
REQ-016 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-017 drop  out  1  one-cycle pulse per discarded zero-length descriptor.

Function
REQ-018 Transfer on a port SHALL occur on a rising edge where valid and ready are both 1.
REQ-019 input_bd_ready SHALL equal !full && !flush; no write-through when full, even with simultaneous output transfer.
REQ-020 Accepted descriptor with burst_len != 0, or any accepted descriptor when DROP_ZERO_LEN=0, SHALL be stored in order; count +1, byte_count +burst_len.
REQ-021 Accepted descriptor with burst_len == 0 and DROP_ZERO_LEN=1 SHALL be discarded: not stored, count/byte_count unchanged, drop=1 next cycle.
REQ-022 Storage SHALL be a DEPTH-entry RAM plus one output register; count includes the output register entry; full when count == DEPTH.
REQ-023 Latency: descriptor stored on edge N into empty FIFO SHALL present output_bd_valid=1 with its fields after edge N+1.
REQ-024 While output_bd_valid=1 and output_bd_ready=0, output_bd_dest/burst_len SHALL hold stable.
REQ-025 Back-to-back: with output_bd_ready=1 continuously and FIFO non-empty, one descriptor SHALL leave per cycle.
REQ-026 Simultaneous store and output transfer SHALL leave count unchanged and update byte_count by +in_len - out_len in one cycle.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-028 empty SHALL equal (count == 0); almost_full SHALL equal (count >= ALMOST_FULL_THRESH); almost_empty SHALL equal (count <= ALMOST_EMPTY_THRESH); all derived from registered count.
REQ-029 byte_count SHALL never overflow: width ADDR_WIDTH+LEN_WIDTH covers DEPTH maximum-length entries.
REQ-030 flush=1 on an edge SHALL empty FIFO: count=0, byte_count=0, output_bd_valid=0, pointers equal; flush overrides a simultaneous write or read (neither counted, output transfer not completed).
REQ-031 output_bd_valid SHALL be 0 whenever count == 0.

Reset
REQ-032 rst_n=0 on a rising edge SHALL clear pointers, count=0, byte_count=0, output_bd_valid=0, drop=0, full=0, empty=1, almost_full=0, almost_empty=1; input_bd_ready=0 while rst_n=0.
REQ-033 Reset mid-operation SHALL discard all contents; first descriptor after release SHALL be the first output.
REQ-034 rst_n SHALL take priority over flush and all handshakes; RAM contents need not be cleared.

Verification
REQ-035 Single write dest=0x12 len=100 at edge N, ready=1 -> output valid after N+1, dest=0x12 len=100; count 1->0, byte_count 100->0.
REQ-036 ADDR_WIDTH=4, output_bd_ready=0, write 17 len=1 -> 16 accepted, full=1, input_bd_ready=0, count=16, byte_count=16; then drain 16 in order, empty=1.
REQ-037 Write len=0 with DROP_ZERO_LEN=1 -> drop pulse 1 cycle, count=0, no output; with DROP_ZERO_LEN=0 -> stored and output.
REQ-038 Steady stream len=10 both sides valid/ready for 3*DEPTH cycles -> count constant, byte_count constant, order preserved across pointer wrap.
REQ-039 Load 5 entries len=8 (byte_count=40), assert flush concurrent with write -> count=0, byte_count=0, output_bd_valid=0 next cycle; written entry absent.
REQ-040 rst_n=0 for one edge with 3 entries held -> all status at reset values; next write/read sequence behaves as from empty.
